// File: rtl/spi_mstr_ss.sv
// spi_mstr_ss
//
// SPI master (mode 3: SCLK idles high, slaves drive on the falling edge and
// sample on the rising edge). It has a built-in five-way slave-select decode.
// One transaction moves one 16-bit word in each direction, MSB first.
//
// Handshake: a transaction is requested by holding wrt high for a cycle while
// busy is low (the FSM is in IDLE). cmd and ss are taken on that same edge and
// are ignored after that. busy rises on the next cycle. When the transaction
// ends, done pulses for one cycle, data becomes valid and busy falls in the
// same cycle. wrt in that done cycle starts the next transaction.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   wrt, cmd[15:0], ss  start request, word to send, target select (0..4, 5-7 none)
//   MISO                serial data from the slaves
//   SCLK, MOSI          SPI clock (idles high) and serial data to the slaves
//   *_ss_n              registered active-low slave selects
//   busy, done, data    transaction status and the received word
module spi_mstr_ss #(
  parameter int SCLK_DIV = 16  // clk cycles per SCLK period; even, >= 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic [2:0]  ss,
  input  logic        MISO,
  output logic        SCLK,
  output logic        MOSI,
  output logic        trig_ss_n,
  output logic        ch1_ss_n,
  output logic        ch2_ss_n,
  output logic        ch3_ss_n,
  output logic        EEP_ss_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] data
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic          sclk_q;
  logic [15:0]   shift_q;
  logic          miso_smp_q;
  logic [4:0]    ss_n_q;      // {EEP, ch3, ch2, ch1, trig}
  logic          busy_q;
  logic          done_q;
  logic [15:0]   data_q;

  // Strobes produced by the next-state logic and consumed by the datapath.
  logic phase_end;
  logic load;
  logic first_fall;   // FRONT -> SHIFT: SCLK falls without a shift
  logic rise;
  logic fall;
  logic finish;

  // Active-low one-hot select for targets 0..4; codes 5..7 select nobody.
  function automatic logic [4:0] ss_decode(input logic [2:0] sel);
    logic [4:0] v;
    v = 5'h1f;
    if (sel < 3'd5) v[sel] = 1'b0;
    return v;
  endfunction

  assign phase_end = (cnt_q == CW'(HALF - 1));

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    first_fall = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wrt) begin
          load    = 1'b1;
          state_d = FRONT;
        end
      end
      FRONT: begin
        if (phase_end) begin
          first_fall = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // SCLK low at the end of a half-period means a rising edge is due.
        if (phase_end) begin
          if (!sclk_q) begin
            rise = 1'b1;
            // The 16th high phase is spent in BACK.
            if (bit_q == 4'd15) state_d = BACK;
          end else begin
            fall = 1'b1;
          end
        end
      end
      BACK: begin
        if (phase_end) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b1;
      shift_q    <= '0;
      miso_smp_q <= 1'b0;
      ss_n_q     <= 5'h1f;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (state_q == IDLE) cnt_q <= '0;
      else                 cnt_q <= phase_end ? '0 : cnt_q + CW'(1);

      if (load) begin
        shift_q <= cmd;
        ss_n_q  <= ss_decode(ss);
        busy_q  <= 1'b1;
        bit_q   <= '0;
      end

      if (first_fall) sclk_q <= 1'b0;

      if (rise) begin
        sclk_q     <= 1'b1;
        miso_smp_q <= MISO;
        bit_q      <= bit_q + 4'd1;
      end

      if (fall) begin
        sclk_q  <= 1'b0;
        shift_q <= {shift_q[14:0], miso_smp_q};
      end

      // The last sampled bit is shifted in on the way out of BACK.
      if (finish) begin
        shift_q <= {shift_q[14:0], miso_smp_q};
        data_q  <= {shift_q[14:0], miso_smp_q};
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        ss_n_q  <= 5'h1f;
      end
    end
  end

  assign SCLK      = sclk_q;
  assign MOSI      = shift_q[15];
  assign trig_ss_n = ss_n_q[0];
  assign ch1_ss_n  = ss_n_q[1];
  assign ch2_ss_n  = ss_n_q[2];
  assign ch3_ss_n  = ss_n_q[3];
  assign EEP_ss_n  = ss_n_q[4];
  assign busy      = busy_q;
  assign done      = done_q;
  assign data      = data_q;

endmodule

// File: tb/tb_spi_mstr_ss.sv
// tb_spi_mstr_ss
//
// Bench for spi_mstr_ss. It contains a mode-3 slave that presents a response
// word MSB first and changes its output after each SCLK rise. The slave can
// also be replaced by a MOSI->MISO loopback. A monitor counts SCLK edges,
// MOSI bits, select and busy activity. Expected results are worked out from
// the transaction rules. A loopback transaction returns cmd; otherwise it
// returns the slave word. Target 0..4 pulls exactly that select low; 5..7
// pulls none. Done arrives 1 + 16T + T/2 cycles after acceptance.
module tb_spi_mstr_ss;

  localparam int T      = 16;
  localparam int LAT    = 1 + 16 * T + T / 2;  // 265
  localparam int SS_LOW = 16 * T + T / 2;      // 264

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic [2:0]  ss;
  logic        miso;
  logic        sclk, mosi, trig_n, ch1_n, ch2_n, ch3_n, eep_n, busy, done;
  logic [15:0] data;

  spi_mstr_ss #(.SCLK_DIV(T)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .ss(ss), .MISO(miso),
    .SCLK(sclk), .MOSI(mosi), .trig_ss_n(trig_n), .ch1_ss_n(ch1_n),
    .ch2_ss_n(ch2_n), .ch3_ss_n(ch3_n), .EEP_ss_n(eep_n),
    .busy(busy), .done(done), .data(data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [4:0]  exp_mask;
  logic [15:0] exp_cmd;
  int          t_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model and monitor ----------------
  logic [15:0] resp = 16'h0;
  bit          loop = 1'b0;
  int          rise_cnt = 0, fall_cnt = 0, sel_low_cnt = 0, busy_cnt = 0;
  int          multi_low_cnt = 0, done_cnt = 0;
  logic [4:0]  low_acc = 5'h0;
  logic [15:0] mosi_word = 16'h0;
  logic        prev_sclk = 1'b1;

  always_comb begin
    miso = 1'b0;
    if (loop)               miso = mosi;
    else if (rise_cnt < 16) miso = resp[4'(15 - rise_cnt)];
  end

  logic [4:0] low_now;
  always @(posedge clk) begin
    #1;
    low_now = ~{eep_n, ch3_n, ch2_n, ch1_n, trig_n};
    if (low_now != 5'h0) sel_low_cnt++;
    if ($countones(low_now) > 1) multi_low_cnt++;
    low_acc = low_acc | low_now;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (sclk && !prev_sclk) begin
      mosi_word = {mosi_word[14:0], mosi};
      rise_cnt++;
    end
    if (!sclk && prev_sclk) fall_cnt++;
    prev_sclk = sclk;
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_data(input bit lp, input logic [15:0] c, input logic [15:0] r);
    return lp ? c : r;
  endfunction

  function automatic logic [4:0] model_mask(input logic [2:0] s);
    return (s < 3'd5) ? (5'd1 << s) : 5'd0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. It requests a transaction and returns one cycle
  // later with the inputs scrambled.
  task automatic start(input logic [15:0] c, input logic [2:0] s, input logic [15:0] r,
                       input bit lp);
    cmd = c; ss = s; wrt = 1'b1; resp = r; loop = lp;
    t_acc = cyc;
    rise_cnt = 0; fall_cnt = 0; sel_low_cnt = 0; busy_cnt = 0;
    multi_low_cnt = 0; done_cnt = 0; low_acc = 5'h0; mosi_word = 16'h0;
    exp_q.push_back(model_data(lp, c, r));
    exp_mask = model_mask(s);
    exp_cmd  = c;
    @(negedge clk);
    wrt = 1'b0;
    cmd = 16'($urandom);
    ss  = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input bit check_tail);
    bit got;
    logic [15:0] e;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc - t_acc), 32'(LAT));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
    check("data", 32'(data), 32'(e));
    check("busy_at_done", 32'(busy), 32'd0);
    check("ss_high_at_done", 32'({eep_n, ch3_n, ch2_n, ch1_n, trig_n}), 32'h1f);
    check("sclk_rises", 32'(rise_cnt), 32'd16);
    check("sclk_falls", 32'(fall_cnt), 32'd16);
    check("mosi_bits", 32'(mosi_word), 32'(exp_cmd));
    check("sel_mask", 32'(low_acc), 32'(exp_mask));
    check("sel_low_cycles", 32'(sel_low_cnt), (exp_mask != 5'h0) ? 32'(SS_LOW) : 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(SS_LOW));
    check("multi_select", 32'(multi_low_cnt), 32'd0);
    if (check_tail) begin
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] cmd;
    logic [2:0]  ss;
    logic [15:0] resp;
    bit          loop;
    logic [15:0] exp_data;
    logic [4:0]  exp_mask;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          got;
    logic [15:0] c, r;
    logic [2:0]  s;
    bit          lp;

    vecs[0] = '{16'hA5C3, 3'd1, 16'h0000, 1'b1, 16'hA5C3, 5'b00010};  // loopback ch1
    vecs[1] = '{16'h0300, 3'd4, 16'h557E, 1'b0, 16'h557E, 5'b10000};  // EEPROM read
    vecs[2] = '{16'h3C5A, 3'd6, 16'h9ABC, 1'b0, 16'h9ABC, 5'b00000};  // invalid target
    vecs[3] = '{16'hFFFF, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 5'b00001};
    vecs[4] = '{16'h0000, 3'd3, 16'hFFFF, 1'b0, 16'hFFFF, 5'b01000};
    vecs[5] = '{16'h8001, 3'd5, 16'h1357, 1'b0, 16'h1357, 5'b00000};
    vecs[6] = '{16'h7FFE, 3'd7, 16'h0000, 1'b1, 16'h7FFE, 5'b00000};

    // Reset with random inputs.
    rst_n = 1'b0; wrt = 1'b0; cmd = 16'h0; ss = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wrt  = 1'($urandom);
      cmd  = 16'($urandom);
      ss   = 3'($urandom_range(0, 7));
      loop = 1'($urandom);
    end
    #1;
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ss", 32'({eep_n, ch3_n, ch2_n, ch1_n, trig_n}), 32'h1f);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    @(negedge clk);
    wrt = 1'b0; loop = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transactions.
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].cmd, vecs[i].ss, vecs[i].resp, vecs[i].loop);
      check("tbl_model_data", 32'(model_data(vecs[i].loop, vecs[i].cmd, vecs[i].resp)),
            32'(vecs[i].exp_data));
      check("tbl_model_mask", 32'(exp_mask), 32'(vecs[i].exp_mask));
      wait_done(1'b1);
      if (vecs[i].ss == 3'd4) check("eep_low_byte", 32'(data[7:0]), 32'h7E);
      repeat (2) @(negedge clk);
    end

    // A wrt pulse in the middle of a transaction is ignored.
    start(16'hC0DE, 3'd1, 16'h2468, 1'b0);
    repeat (49) @(negedge clk);
    cmd = 16'h1234; ss = 3'd0; wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    wait_done(1'b1);

    // Back-to-back: wrt in the done cycle.
    start(16'h5AA5, 3'd1, 16'h0000, 1'b1);
    wait_done(1'b0);
    check("b2b_trig_high", 32'(trig_n), 32'd1);
    start(16'h0F0F, 3'd0, 16'hBEEF, 1'b0);
    check("b2b_trig_low", 32'(trig_n), 32'd0);
    wait_done(1'b1);
    repeat (3) @(negedge clk);

    // Randomized transactions against the model.
    for (int n = 0; n < 12; n++) begin
      c  = 16'($urandom);
      r  = 16'($urandom);
      s  = 3'($urandom_range(0, 7));
      lp = 1'($urandom);
      start(c, s, r, lp);
      wait_done(1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a transaction.
    start(16'($urandom), 3'd3, 16'($urandom), 1'b0);
    void'(exp_q.pop_back());
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rise_cnt >= 8) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst_reached", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss", 32'({eep_n, ch3_n, ch2_n, ch1_n, trig_n}), 32'h1f);
    check("mid_rst_sclk", 32'(sclk), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    done_cnt = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    r = 16'($urandom);
    start(16'h00FF, 3'd2, r, 1'b0);
    wait_done(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
